// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice: RV32 base opcodes, FSM state type and
// the default instruction length. Optional feature macro: PC_MISALIGN_TRAP_EN adds StTrap.
package pc_sequencer_pkg;

    // RV32 base opcode field values (inst[6:0])
    localparam logic [6:0] OPC_R  = 7'b0110011;  // OP
    localparam logic [6:0] OPC_I1 = 7'b0010011;  // OP-IMM
    localparam logic [6:0] OPC_I2 = 7'b0000011;  // LOAD
    localparam logic [6:0] OPC_I3 = 7'b1100111;  // JALR
    localparam logic [6:0] OPC_S  = 7'b0100011;  // STORE
    localparam logic [6:0] OPC_U1 = 7'b0110111;  // LUI
    localparam logic [6:0] OPC_U2 = 7'b0010111;  // AUIPC
    localparam logic [6:0] OPC_B  = 7'b1100011;  // BRANCH
    localparam logic [6:0] OPC_J  = 7'b1101111;  // JAL

    localparam int unsigned ILEN_DEFAULT = 4;

    typedef enum logic [1:0] {
        StBoot = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
`ifdef PC_MISALIGN_TRAP_EN
        ,
        StTrap = 2'b11
`endif
    } pcState_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target calculation: relative (pc + offset) or absolute with bit 0 cleared,
// plus a flag for a target that is not 4-byte aligned.
module pc_target_calc #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] iPC,
    input  logic            iRel,
    input  logic [XLEN-1:0] iTarget,
    output logic [XLEN-1:0] oTarget,
    output logic            oMisalign
);

    // Select relative/absolute target; absolute form drops bit 0 like JALR
    always_comb begin
        oTarget   = iRel ? (iPC + iTarget) : {iTarget[XLEN-1:1], 1'b0};
        oMisalign = |oTarget[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT -> RUN -> HALT, with sequential advance, stall and
// branch/jump redirect. Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect
// targets go through a one-cycle TRAP state to TRAP_VECTOR instead of being force-aligned).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     ILEN_BYTES   = ILEN_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iFetchReady,
    input  logic            iStall,
    input  logic            iRedirValid,
    input  logic            iRedirRel,
    input  logic [XLEN-1:0] iRedirTarget,
    input  logic            iHalt,
    output logic [XLEN-1:0] oPC,
    output logic            oPCValid,
    output logic [XLEN-1:0] oFetchCount,
    output logic            oHalted,
    output logic            oMisalign
);

    pcState_e        stateQ;
    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] countQ;
    logic [XLEN-1:0] calcTarget;
    logic            calcMisalign;
    logic            fetchAccept;

    pc_target_calc #(
        .XLEN (XLEN)
    ) uTargetCalc (
        .iPC       (pcQ),
        .iRel      (iRedirRel),
        .iTarget   (iRedirTarget),
        .oTarget   (calcTarget),
        .oMisalign (calcMisalign)
    );

    // Fetch handshake; valid only in RUN so BOOT/HALT/TRAP never count
    always_comb begin
        fetchAccept = oPCValid & iFetchReady & ~iStall;
    end

    // Sequencer FSM with registered PC and fetch counter; halt > redirect > stall > advance
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            stateQ <= StBoot;
            pcQ    <= RESET_VECTOR;
            countQ <= '0;
        end else begin
            unique case (stateQ)
                StBoot: stateQ <= StRun;
                StRun: begin
                    if (iHalt) begin
                        stateQ <= StHalt;
                    end else if (iRedirValid) begin
                        if (fetchAccept) countQ <= countQ + XLEN'(1);
`ifdef PC_MISALIGN_TRAP_EN
                        if (calcMisalign) begin
                            stateQ <= StTrap;
                            pcQ    <= TRAP_VECTOR;
                        end else begin
                            pcQ <= calcTarget;
                        end
`else
                        pcQ <= {calcTarget[XLEN-1:2], 2'b00};
`endif
                    end else if (fetchAccept) begin
                        pcQ    <= pcQ + XLEN'(ILEN_BYTES);
                        countQ <= countQ + XLEN'(1);
                    end
                end
                StHalt: stateQ <= StHalt;
`ifdef PC_MISALIGN_TRAP_EN
                StTrap: stateQ <= StRun;
`endif
                default: stateQ <= StBoot;
            endcase
        end
    end

    // Status outputs decoded from state only
    always_comb begin
        oPC         = pcQ;
        oFetchCount = countQ;
        oPCValid    = (stateQ == StRun);
        oHalted     = (stateQ == StHalt);
`ifdef PC_MISALIGN_TRAP_EN
        oMisalign   = (stateQ == StTrap);
`else
        oMisalign   = 1'b0;
`endif
    end

`ifndef PC_MISALIGN_TRAP_EN
    // Low target bits and the misalign flag are deliberately dropped in the force-align build
    logic unusedTargetBits;
    assign unusedTargetBits = ^{calcTarget[1:0], calcMisalign};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic        iCLK;
    logic        iRST;
    logic        iFetchReady;
    logic        iStall;
    logic        iRedirValid;
    logic        iRedirRel;
    logic [31:0] iRedirTarget;
    logic        iHalt;
    logic [31:0] oPC;
    logic        oPCValid;
    logic [31:0] oFetchCount;
    logic        oHalted;
    logic        oMisalign;

    int nChecks = 0;
    int nFails  = 0;

    pc_sequencer dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iFetchReady  (iFetchReady),
        .iStall       (iStall),
        .iRedirValid  (iRedirValid),
        .iRedirRel    (iRedirRel),
        .iRedirTarget (iRedirTarget),
        .iHalt        (iHalt),
        .oPC          (oPC),
        .oPCValid     (oPCValid),
        .oFetchCount  (oFetchCount),
        .oHalted      (oHalted),
        .oMisalign    (oMisalign)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Advance one rising edge and settle 1ns past it
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic redir(input logic rel, input logic [31:0] tgt);
        iRedirValid  = 1'b1;
        iRedirRel    = rel;
        iRedirTarget = tgt;
    endtask

    task automatic test_reset();
        logic [31:0] expPc [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] expCnt[5] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3};
        logic        expVal[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        #2;
        nChecks++; if (oPC !== 32'h0) begin nFails++; $display("FAIL rst_pc got %h exp 0", oPC); end
        nChecks++; if (oPCValid !== 1'b0) begin nFails++; $display("FAIL rst_valid got %b exp 0", oPCValid); end
        nChecks++; if (oFetchCount !== 32'h0) begin nFails++; $display("FAIL rst_cnt got %h exp 0", oFetchCount); end
        nChecks++; if (oHalted !== 1'b0) begin nFails++; $display("FAIL rst_halted got %b exp 0", oHalted); end
        nChecks++; if (oMisalign !== 1'b0) begin nFails++; $display("FAIL rst_mis got %b exp 0", oMisalign); end
        iFetchReady = 1'b1;
        #2 iRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step();
            nChecks++;
            if (oPC !== expPc[i] || oPCValid !== expVal[i] || oFetchCount !== expCnt[i]) begin
                nFails++;
                $display("FAIL boot_seq[%0d] got pc=%h v=%b c=%0d exp pc=%h v=%b c=%0d", i, oPC,
                         oPCValid, oFetchCount, expPc[i], expVal[i], expCnt[i]);
            end
        end
        iFetchReady = 1'b0;
    endtask

    task automatic test_stall_redirect();
        redir(1'b0, 32'h8);
        step();
        iRedirValid = 1'b0;
        nChecks++; if (oPC !== 32'h8) begin nFails++; $display("FAIL stall_setup got %h exp 8", oPC); end
        iStall = 1'b1; iFetchReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            nChecks++;
            if (oPC !== 32'h8 || oFetchCount !== 32'd3) begin
                nFails++;
                $display("FAIL stall_hold[%0d] got pc=%h c=%0d exp pc=8 c=3", i, oPC, oFetchCount);
            end
        end
        redir(1'b1, 32'd16);
        step();
        iRedirValid = 1'b0;
        nChecks++;
        if (oPC !== 32'd24 || oFetchCount !== 32'd3) begin
            nFails++;
            $display("FAIL stall_redir got pc=%h c=%0d exp pc=18 c=3", oPC, oFetchCount);
        end
        iStall = 1'b0;
    endtask

    task automatic test_back_to_back();
        iFetchReady = 1'b1;
        redir(1'b1, 32'hFFFF_FFF8);  // 24 - 8
        step();
        nChecks++;
        if (oPC !== 32'd16 || oFetchCount !== 32'd4) begin
            nFails++;
            $display("FAIL b2b_rel_neg got pc=%h c=%0d exp pc=10 c=4", oPC, oFetchCount);
        end
        redir(1'b0, 32'h201);
        step();
        iRedirValid = 1'b0;
        nChecks++;
        if (oPC !== 32'h200 || oFetchCount !== 32'd5) begin
            nFails++;
            $display("FAIL b2b_abs got pc=%h c=%0d exp pc=200 c=5", oPC, oFetchCount);
        end
        step();
        nChecks++;
        if (oPC !== 32'h204 || oFetchCount !== 32'd6) begin
            nFails++;
            $display("FAIL b2b_seq got pc=%h c=%0d exp pc=204 c=6", oPC, oFetchCount);
        end
        iFetchReady = 1'b0;
    endtask

    task automatic test_misalign();
        redir(1'b0, 32'h14);
        step();
        nChecks++; if (oPC !== 32'h14) begin nFails++; $display("FAIL mis_setup got %h exp 14", oPC); end
        redir(1'b0, 32'h41);
        step();
        nChecks++; if (oPC !== 32'h40) begin nFails++; $display("FAIL mis_bit0 got %h exp 40", oPC); end
        redir(1'b0, 32'h42);
        step();
        iRedirValid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        nChecks++;
        if (oPC !== 32'h100 || oMisalign !== 1'b1 || oPCValid !== 1'b0) begin
            nFails++;
            $display("FAIL mis_trap got pc=%h m=%b v=%b exp pc=100 m=1 v=0", oPC, oMisalign, oPCValid);
        end
        step();
        nChecks++;
        if (oPC !== 32'h100 || oMisalign !== 1'b0 || oPCValid !== 1'b1) begin
            nFails++;
            $display("FAIL mis_after got pc=%h m=%b v=%b exp pc=100 m=0 v=1", oPC, oMisalign, oPCValid);
        end
`else
        nChecks++;
        if (oPC !== 32'h40 || oMisalign !== 1'b0 || oPCValid !== 1'b1) begin
            nFails++;
            $display("FAIL mis_force got pc=%h m=%b v=%b exp pc=40 m=0 v=1", oPC, oMisalign, oPCValid);
        end
`endif
        nChecks++;
        if (oFetchCount !== 32'd6) begin nFails++; $display("FAIL mis_cnt got %0d exp 6", oFetchCount); end
    endtask

    task automatic test_wrap_async_reset();
        redir(1'b0, 32'hFFFF_FFFC);
        step();
        iRedirValid = 1'b0;
        nChecks++; if (oPC !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL wrap_setup got %h exp fffffffc", oPC); end
        iFetchReady = 1'b1;
        step();
        nChecks++;
        if (oPC !== 32'h0 || oFetchCount !== 32'd7) begin
            nFails++;
            $display("FAIL wrap got pc=%h c=%0d exp pc=0 c=7", oPC, oFetchCount);
        end
        step();  // pc=4, count=8
        redir(1'b1, 32'h40);
        #1 iRST = 1'b0;
        #1;
        nChecks++;
        if (oPC !== 32'h0 || oFetchCount !== 32'h0 || oPCValid !== 1'b0 || oHalted !== 1'b0 ||
            oMisalign !== 1'b0) begin
            nFails++;
            $display("FAIL async_rst got pc=%h c=%0d v=%b h=%b m=%b exp all 0", oPC, oFetchCount,
                     oPCValid, oHalted, oMisalign);
        end
        iRedirValid = 1'b0; iFetchReady = 1'b0;
        #2 iRST = 1'b1;
        step();
        nChecks++;
        if (oPCValid !== 1'b1 || oPC !== 32'h0) begin
            nFails++;
            $display("FAIL rst_to_run got pc=%h v=%b exp pc=0 v=1", oPC, oPCValid);
        end
    endtask

    task automatic test_halt();
        iFetchReady = 1'b1;
        step();
        nChecks++;
        if (oPC !== 32'h4 || oFetchCount !== 32'd1) begin
            nFails++;
            $display("FAIL halt_setup got pc=%h c=%0d exp pc=4 c=1", oPC, oFetchCount);
        end
        iFetchReady = 1'b0;
        iHalt = 1'b1;
        redir(1'b0, 32'h50);
        step();
        iHalt = 1'b0;
        nChecks++;
        if (oHalted !== 1'b1 || oPCValid !== 1'b0 || oPC !== 32'h4) begin
            nFails++;
            $display("FAIL halt_enter got h=%b v=%b pc=%h exp h=1 v=0 pc=4", oHalted, oPCValid, oPC);
        end
        redir(1'b1, 32'h60);
        iFetchReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            nChecks++;
            if (oHalted !== 1'b1 || oPC !== 32'h4 || oFetchCount !== 32'd1 || oPCValid !== 1'b0) begin
                nFails++;
                $display("FAIL halt_hold[%0d] got h=%b pc=%h c=%0d v=%b exp h=1 pc=4 c=1 v=0", i,
                         oHalted, oPC, oFetchCount, oPCValid);
            end
        end
        iRedirValid = 1'b0; iFetchReady = 1'b0;
        #1 iRST = 1'b0;
        #1;
        nChecks++;
        if (oHalted !== 1'b0 || oPC !== 32'h0 || oFetchCount !== 32'h0) begin
            nFails++;
            $display("FAIL halt_rst got h=%b pc=%h c=%0d exp h=0 pc=0 c=0", oHalted, oPC, oFetchCount);
        end
        #2 iRST = 1'b1;
        step();
        nChecks++; if (oPCValid !== 1'b1) begin nFails++; $display("FAIL halt_rst_run got v=%b exp 1", oPCValid); end
    endtask

    initial begin
        iRST = 1'b0; iFetchReady = 1'b0; iStall = 1'b0; iRedirValid = 1'b0;
        iRedirRel = 1'b0; iRedirTarget = '0; iHalt = 1'b0;
        test_reset();
        test_stall_redirect();
        test_back_to_back();
        test_misalign();
        test_wrap_async_reset();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, 32, width of PC, targets and fetch counter.
REQ-002 Parameter RESET_VECTOR, 0, PC value loaded at reset.
REQ-003 Parameter ILEN_BYTES, 4, sequential increment in bytes.
REQ-004 Parameter TRAP_VECTOR, 32'h100, PC loaded on misaligned redirect (REQ-030 only).
REQ-005 iCLK  in  1  clock, all state updates on rising edge.
REQ-006 iRST  in  1  reset, asynchronous, active-low.
REQ-007 iFetchReady  in  1  fetch stage accepts oPC this cycle.
REQ-008 iStall  in  1  hold PC; blocks sequential advance.
REQ-009 iRedirValid  in  1  branch/jump redirect request, single-cycle.
REQ-010 iRedirRel  in  1  1: target = oPC + iRedirTarget (B/J); 0: target = iRedirTarget with bit 0 cleared (JALR).
REQ-011 iRedirTarget  in  XLEN  signed offset or absolute address per iRedirRel.
REQ-012 iHalt  in  1  stop fetching.
REQ-013 oPC  out  XLEN  current fetch address.
REQ-014 oPCValid  out  1  oPC is a valid fetch request.
REQ-015 oFetchCount  out  XLEN  number of accepted fetches.
REQ-016 oHalted  out  1  block in HALT state.
REQ-017 oMisalign  out  1  one-cycle pulse on misaligned redirect target (REQ-030 only; else tied 0).

Function
REQ-018 FSM states BOOT, RUN, HALT (plus TRAP under REQ-030); encoding 2 bits.
REQ-019 BOOT: entered on reset, lasts exactly one cycle, oPCValid=0, then RUN.
REQ-020 RUN: oPCValid=1; accepted fetch = oPCValid & iFetchReady & !iStall.
REQ-021 On accepted fetch without redirect, oPC <= oPC + ILEN_BYTES next edge; oFetchCount += 1.
REQ-022 Redirect in RUN loads target next edge regardless of iStall/iFetchReady; oFetchCount increments only if the same cycle is also an accepted fetch.
REQ-023 Priority per cycle: iHalt > iRedirValid > iStall > sequential advance.
REQ-024 iHalt in RUN: next state HALT, oPC holds, oPCValid=0 from next cycle; HALT is exited only by reset.
REQ-025 Redirect in BOOT or HALT is ignored.
REQ-026 All PC/counter arithmetic modulo 2^XLEN; 'hFFFF_FFFC + 4 wraps to 0; count wraps silently.
REQ-027 Without REQ-030, target bits [1:0] forced to 0 before load.
REQ-028 oPC, oFetchCount are registered outputs; oPCValid, oHalted decoded from state only (no input-to-output path).

Reset
REQ-029 iRST low: state=BOOT, oPC=RESET_VECTOR, oFetchCount=0, oPCValid=0, oHalted=0, oMisalign=0, immediately and asynchronously, including mid-redirect or in HALT; no simulation termination on reset.

Configuration
REQ-030 Macro PC_MISALIGN_TRAP_EN defined: redirect target with [1:0]!=0 sets state TRAP for one cycle, oPC <= TRAP_VECTOR, oMisalign=1 that cycle, oPCValid=0, then RUN; undefined: no TRAP state, REQ-027 applies, oMisalign constant 0.

Structure
REQ-031 Shared package holds opcode constants (R, I1, I2, I3, S, U1, U2, B, J), FSM state typedef and ILEN default.
REQ-032 Sub-module pc_target_calc (combinational: rel/abs select, bit-0 clear, alignment check) instantiated once.

Verification
REQ-033 Reset release, iFetchReady=1 four cycles -> oPC 0,0(BOOT, valid=0),4,8,12; oFetchCount=3.
REQ-034 oPC=8, iStall=1 two cycles, then redirect rel +16 -> oPC holds 8, then 24 next edge; count unchanged.
REQ-035 oPC=20, redirect abs 'h41, iRedirRel=0 -> oPC='h40 (macro off) / oPC='h100, oMisalign pulse (macro on: 'h41 bit0 cleared -> 'h40 aligned, so use 'h42 -> TRAP).
REQ-036 Same cycle iHalt=1 and redirect -> HALT, oPC unchanged, oHalted=1, oPCValid=0; later redirects ignored.
REQ-037 oPC='hFFFF_FFFC accepted fetch -> oPC=0; iRST pulsed low mid-cycle -> all outputs at reset values before next edge.
